// File: rtl/unit_l_arbiter_pkg.sv
// Shared function codes, FSM state encoding and the unit_L evaluation helper.
// Combinational helper only; no latency or flow control lives here.
package unit_l_arbiter_pkg;

    localparam logic [1:0] F_ILL = 2'b00;
    localparam logic [1:0] F_AND = 2'b01;
    localparam logic [1:0] F_OR  = 2'b10;
    localparam logic [1:0] F_XOR = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_e;

    function automatic logic [31:0] unit_l_eval(input logic [31:0] a,
                                                input logic [31:0] b,
                                                input logic [1:0]  f);
        logic [31:0] y;
        case (f)
            F_AND:   y = a & b;
            F_OR:    y = a | b;
            F_XOR:   y = a ^ b;
            default: y = '0;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/unit_l_arbiter_if.sv
// Request/response bundle between the two requesters, the arbiter and the consumer.
// Request side is valid/ready per requester; response side is a single valid/ready channel.
interface unit_l_arbiter_if;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic [1:0]  req0_f;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic [1:0]  req1_f;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        busy;

    modport slave (
        input  req_valid, req0_a, req0_b, req0_f, req1_a, req1_b, req1_f, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, busy
    );

    modport master (
        output req_valid, req0_a, req0_b, req0_f, req1_a, req1_b, req1_f, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, busy
    );
endinterface

// File: rtl/unit_l_arbiter_unit_l.sv
// Shared 32-bit AND/OR/XOR logic unit, purely combinational (multi-cycle path by design).
// Inputs come straight from the arbiter's operand registers; no flow control.
module unit_l_arbiter_unit_l
    import unit_l_arbiter_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [1:0]  f_i,
    output logic [31:0] y_o
);
    assign y_o = unit_l_eval(a_i, b_i, f_i);
endmodule

// File: rtl/unit_l_arbiter.sv
// Round-robin arbiter sharing one unit_L between two requesters.
// Response LAT edges after accept (error: on the accept edge); holds RESP while rsp_ready=0.
module unit_l_arbiter
    import unit_l_arbiter_pkg::*;
#(
    parameter int LAT = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    unit_l_arbiter_if.slave    bus
);
    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(LAT - 1);

    state_e          state_q, state_d;
    logic            rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [31:0]     op_a_q, op_a_d, op_b_q, op_b_d;
    logic [1:0]      op_f_q, op_f_d;
    logic            op_id_q, op_id_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [31:0]     rsp_data_q, rsp_data_d;
    logic            rsp_id_q, rsp_id_d;
    logic            rsp_err_q, rsp_err_d;

    logic [1:0]      grant;
    logic            acc_vld;
    logic            acc_id;
    logic [31:0]     acc_a, acc_b;
    logic [1:0]      acc_f;
    logic [31:0]     unit_y;

    // Grant is gated by rst_n so req_ready reads 00 the moment reset asserts.
    always_comb begin
        grant = 2'b00;
        if (rst_n && state_q == S_IDLE) begin
            case (bus.req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = rr_ptr_q ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
    end

    assign acc_vld = |(bus.req_valid & grant);
    assign acc_id  = grant[1];
    assign acc_a   = acc_id ? bus.req1_a : bus.req0_a;
    assign acc_b   = acc_id ? bus.req1_b : bus.req0_b;
    assign acc_f   = acc_id ? bus.req1_f : bus.req0_f;

    unit_l_arbiter_unit_l u_unit_l (
        .a_i (op_a_q),
        .b_i (op_b_q),
        .f_i (op_f_q),
        .y_o (unit_y)
    );

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        cnt_d       = cnt_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        op_f_d      = op_f_q;
        op_id_d     = op_id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            S_IDLE: begin
                if (acc_vld) begin
                    op_a_d   = acc_a;
                    op_b_d   = acc_b;
                    op_f_d   = acc_f;
                    op_id_d  = acc_id;
                    rr_ptr_d = ~acc_id;
                    if (acc_f == F_ILL) begin
                        // Illegal op never touches unit_L and answers immediately.
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_data_d  = '0;
                        rsp_id_d    = acc_id;
                    end else begin
                        state_d = S_EXEC;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            S_EXEC: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_data_d  = unit_y;
                    rsp_id_d    = op_id_q;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= 1'b0;
            cnt_q       <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_f_q      <= F_ILL;
            op_id_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            cnt_q       <= cnt_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_f_q      <= op_f_d;
            op_id_q     <= op_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bus.req_ready = grant;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule
